// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage request / result bundle between the pipeline and the HI/LO mul-div controller.
interface muldiv_hilo_ctrl_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;

    logic            flush;
    logic            req_valid;
    logic [OP_W-1:0] req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi_rdata;
    logic [XLEN-1:0] lo_rdata;

    modport master (
        output flush, req_valid, req_op, req_a, req_b,
        input  stall, busy, done, hi_rdata, lo_rdata
    );

    modport slave (
        input  flush, req_valid, req_op, req_a, req_b,
        output stall, busy, done, hi_rdata, lo_rdata
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with a radix-2 restoring divider.
// Define HILO_BYPASS_EN to forward same-cycle HI/LO writes onto hi_rdata/lo_rdata.
module muldiv_hilo_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               resetn,
    muldiv_hilo_ctrl_if.slave  bus
);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned DIV_STEPS = 32;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              sgn_q, sgn_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              div0_q, div0_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              is_mtlo, is_mthi, is_divu, is_div, is_multu, is_mult, is_md;
    logic              live, accept;
    logic              hi_we, lo_we, done_c, stall_c;
    logic [XLEN-1:0]   hi_wdata, lo_wdata;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_step, quo_step;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        sgn_d    = sgn_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = '0;
        lo_wdata = '0;
        done_c   = 1'b0;

        // Illegal multi-hot opcodes resolve MTLO > MTHI > DIVU > DIV > MULTU > MULT
        is_mtlo  = bus.req_op[5];
        is_mthi  = !bus.req_op[5] && bus.req_op[4];
        is_divu  = !(|bus.req_op[5:4]) && bus.req_op[3];
        is_div   = !(|bus.req_op[5:3]) && bus.req_op[2];
        is_multu = !(|bus.req_op[5:2]) && bus.req_op[1];
        is_mult  = !(|bus.req_op[5:1]) && bus.req_op[0];
        is_md    = is_divu || is_div || is_multu || is_mult;

        live     = resetn && !bus.flush;
        accept   = (state_q == ST_IDLE) && bus.req_valid && live;

        mul_a    = {{XLEN{sgn_q & opa_q[XLEN-1]}}, opa_q};
        mul_b    = {{XLEN{sgn_q & opb_q[XLEN-1]}}, opb_q};
        prod     = mul_a * mul_b;

        // One restoring step: shift in the next dividend bit, subtract if it fits
        div_shift = {rem_q, opa_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = !div_diff[XLEN];
        rem_step  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_step  = {opa_q[XLEN-2:0], div_ge};

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mtlo) begin
                        lo_we    = 1'b1;
                        lo_wdata = bus.req_a;
                    end else if (is_mthi) begin
                        hi_we    = 1'b1;
                        hi_wdata = bus.req_a;
                    end else if (is_divu || is_div) begin
                        state_d = ST_DIV;
                        rem_d   = '0;
                        if (bus.req_b == '0) begin
                            div0_d = 1'b1;
                            cnt_d  = DIV_LAST;
                        end else begin
                            div0_d = 1'b0;
                            cnt_d  = CNT_W'(1);
                            opa_d  = (is_div && bus.req_a[XLEN-1]) ? -bus.req_a : bus.req_a;
                            opb_d  = (is_div && bus.req_b[XLEN-1]) ? -bus.req_b : bus.req_b;
                            qneg_d = is_div && (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]);
                            rneg_d = is_div && bus.req_a[XLEN-1];
                        end
                    end else if (is_multu || is_mult) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(1);
                        opa_d   = bus.req_a;
                        opb_d   = bus.req_b;
                        sgn_d   = is_mult;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    done_c   = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    hi_we    = 1'b1;
                    lo_we    = 1'b1;
                    hi_wdata = prod[2*XLEN-1:XLEN];
                    lo_wdata = prod[XLEN-1:0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (!div0_q) begin
                    opa_d = quo_step;
                    rem_d = rem_step;
                end
                if (cnt_q == DIV_LAST) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!div0_q) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        lo_wdata = qneg_q ? -quo_step : quo_step;
                        hi_wdata = rneg_q ? -rem_step : rem_step;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A cancelled EX instruction aborts everything, including a coinciding completion
        if (!live) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_we   = 1'b0;
            lo_we   = 1'b0;
            done_c  = 1'b0;
        end

        hi_d    = hi_we ? hi_wdata : hi_q;
        lo_d    = lo_we ? lo_wdata : lo_q;
        busy_d  = (state_d != ST_IDLE);
        stall_c = live && ((accept && is_md) || ((state_q != ST_IDLE) && !done_c));
    end

    assign bus.stall = stall_c;
    assign bus.done  = done_c;
    assign bus.busy  = busy_q;

`ifdef HILO_BYPASS_EN
    assign bus.hi_rdata = hi_we ? hi_wdata : hi_q;
    assign bus.lo_rdata = lo_we ? lo_wdata : lo_q;
`else
    assign bus.hi_rdata = hi_q;
    assign bus.lo_rdata = lo_q;
`endif

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Sequences multi-cycle MULT/MULTU/DIV/DIVU execution in the EX stage and owns the architectural HI/LO registers.
- Takes one-hot op requests from the decoded control bundle together with rs/rt data.
- Drives a pipeline stall while an operation is in flight, writes HI/LO on completion, and serves MFHI/MFLO reads.
- Contains a radix-2 restoring divider (one quotient bit per cycle) and a latency-configurable multiplier pipeline.

Parameters:
- MUL_LAT, 2, cycles from MULT/MULTU acceptance to completion; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- flush  input  1  EX instruction cancelled (exception/ERET); aborts any operation
- req_valid  input  1  EX stage holds a valid instruction
- req_op  input  6  one-hot [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MTHI [5]MTLO
- req_a  input  32  rs_data
- req_b  input  32  rt_data
- stall  output  1  hold IF/ID/EX; combinational
- busy  output  1  state != IDLE; registered
- done  output  1  one-cycle pulse: HI/LO written at end of this cycle
- hi_rdata  output  32  HI value
- lo_rdata  output  32  LO value

Behaviour:
- Reset (async, resetn=0): state IDLE, HI=LO=0, cnt=0, operand/partial registers 0, busy=0; done=0, stall=0.
- States: IDLE, MUL, DIV.
- Accept: only in IDLE, when req_valid & !flush. Call this cycle T0.
  - MTHI/MTLO: HI/LO <= req_a at end of T0. State stays IDLE. No stall, no done.
  - MULT/MULTU: latch operands and signedness, go to MUL. cnt counts 1..MUL_LAT. done=1 in cycle T(MUL_LAT). HI=product[63:32], LO=product[31:0]. MULT is 64-bit signed; MULTU is unsigned.
  - DIV/DIVU: if req_b==0, go to DIV with cnt=32: done in T1, HI/LO unchanged. Otherwise latch |a| and |b| (signed) or raw values (unsigned), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]), then go to DIV. Iterations run in T1..T32, one quotient bit each, MSB first. done=1 in T32. The sign-corrected quotient is written to LO and the remainder to HI at end of T32.
- stall = !flush & ((IDLE & req_valid & (MULT|MULTU|DIV|DIVU)) | (busy & !done)).
  - stall is high from T0 through the cycle before done, and low in the done cycle, so EX advances exactly once.
  - After completion the state returns to IDLE on the done edge. The finished instruction has already left EX, so it is never re-accepted.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (32-bit wrap, no trap).
- flush in any state: stall=0 that cycle; next edge state=IDLE, cnt=0. No HI/LO write. done is forced 0 in the flush cycle, even if completion coincides.
- flush in IDLE with a request: nothing is accepted and no MTHI/MTLO write occurs.
- req_op with multiple bits set is illegal. Priority is MTLO > MTHI > DIVU > DIV > MULTU > MULT; no assertion fires.
- Requests arriving while busy are ignored. The pipeline is stalled, so the only legal case is the in-flight instruction itself.
- hi_rdata/lo_rdata are the registered HI/LO values (but see Optional Feature).

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: hi_rdata/lo_rdata combinationally forward any value being written this cycle: MTHI/MTLO data in T0, or the mul/div result in the done cycle. An MFHI/MFLO that reads in the same cycle sees the new value.
- Undefined: outputs are purely registered. The hazard unit must insert one bubble between a HI/LO writer and a dependent MFHI/MFLO.

Test Plan:
- MULT, a=0xFFFFFFFE, b=0x00000003, MUL_LAT=2 -> stall high T0..T1, done in T2, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, same operands -> HI=0x00000002, LO=0xFFFFFFFA; stall exactly 2 cycles.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> stall 32 cycles (T0..T31), done in T32, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0x80000000/0x10 -> LO=0x08000000, HI=0.
- DIV with b=0 after MTHI 0x1234 / MTLO 0x5678 -> done in T1, HI=0x1234, LO=0x5678 unchanged, stall only in T0.
- DIVU in flight, flush asserted in T10 -> stall low in T10, no done, HI/LO unchanged, state IDLE in T11. MTLO 0xAA in T11 -> LO=0xAA at end of T11.
- resetn pulsed low mid-DIV at T15 -> busy=0, stall=0, HI=LO=0 immediately. After release, a new MULT completes normally. With HILO_BYPASS_EN, MTHI 0x55 gives hi_rdata=0x55 already in T0.
